deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
Receive-side counterpart of the team's serializer. It samples a serial MSB-first bit stream qualified by a valid strobe and reassembles it into parallel words. Words can be full-width or partial, and a partial word is closed when the valid strobe drops. Each word is output with a data_mod count that uses the same encoding the serializer accepts, so the two blocks form a loopback pair.

Parameters:
DATA_BUS_WIDTH, 16, parallel word width in bits; must be at least 4.
DATA_MOD_WIDTH, 4, width of the bit-count field; equals $clog2(DATA_BUS_WIDTH).

Ports:
clk_i  input  1  clock; all logic on posedge.
arst_n_i  input  1  asynchronous active-low reset.
ser_data_i  input  1  serial data bit, MSB of the word first.
ser_data_val_i  input  1  qualifies ser_data_i; high for consecutive cycles during a burst.
deser_data_o  output  DATA_BUS_WIDTH  assembled word; first received bit is at index DATA_BUS_WIDTH-1.
deser_data_mod_o  output  DATA_MOD_WIDTH  number of valid bits; 0 means all DATA_BUS_WIDTH bits are valid.
deser_data_val_o  output  1  one-cycle pulse marking a new word on deser_data_o and deser_data_mod_o.
busy_o  output  1  high while a word is partially assembled (RECV state).

Behaviour:
- Reset (arst_n_i low, asynchronous):
  - State goes to IDLE; bit counter and shift buffer clear.
  - deser_data_o = 0, deser_data_mod_o = 0, deser_data_val_o = 0, busy_o = 0.
  - Any partial word is discarded with no output pulse.
- States are IDLE and RECV. busy_o is 1 exactly when the state is RECV.
- Bit counter is bit_cnt (DATA_MOD_WIDTH bits, range 0..DATA_BUS_WIDTH-1).
- Bit placement: the bit sampled with bit_cnt = k is stored at buffer index DATA_BUS_WIDTH-1-k.
- IDLE:
  - ser_data_val_i = 1: store the bit at index DATA_BUS_WIDTH-1, set bit_cnt = 1, go to RECV.
  - Otherwise stay in IDLE.
- RECV with ser_data_val_i = 1:
  - Store the bit and increment bit_cnt.
  - If this is the DATA_BUS_WIDTH-th bit (bit_cnt was DATA_BUS_WIDTH-1), the word is complete:
    - Registered outputs load the buffer, and deser_data_mod_o is set to 0.
    - deser_data_val_o is high in the following cycle, giving 1 cycle latency after the last bit edge.
    - bit_cnt clears and the state returns to IDLE.
- RECV with ser_data_val_i = 0 (burst ended) and bit_cnt = n:
  - n >= 3: the partial word is emitted in the next cycle.
    - deser_data_o holds the n received bits in the top positions; lower bits are 0.
    - deser_data_mod_o = n.
  - n = 1 or 2: the fragment is discarded with no pulse, matching the serializer, which never sends 1- or 2-bit transactions.
  - In both cases the state returns to IDLE and the buffer clears.
- Back-to-back bursts:
  - A continuous valid stream longer than DATA_BUS_WIDTH bits is split into consecutive full words, one pulse every DATA_BUS_WIDTH cycles.
  - If valid stays high after the word-completing edge, the next bit is taken in IDLE in the next cycle, so no bit is lost.
- deser_data_o and deser_data_mod_o hold their last emitted value until the next pulse.
- deser_data_val_o is never high for two consecutive cycles unless two words complete on consecutive edges. That cannot happen for DATA_BUS_WIDTH >= 4.
- ser_data_i is ignored whenever ser_data_val_i = 0.

Optional Feature:
DESERIALIZER_FRAG_ERR_EN
- Defined: adds output port frag_err_o (1 bit, reset value 0). It pulses for one cycle, with the same timing a word pulse would have, whenever a 1- or 2-bit fragment is discarded.
- Undefined: the port is absent and fragments are dropped silently.

Decomposition:
- Shared package ser_pkg, used by both serializer and deserializer:
  - state enum typedef {IDLE_S, RECV_S/WORK_S};
  - localparam MIN_TRANSACTION_LEN = 3;
  - helper function converting a bit count to the data_mod encoding (DATA_BUS_WIDTH maps to 0).
- No sub-module; a single flat module of about 150 lines.

Test Plan:
1. Full word: 16 contiguous valid bits of 0xA5C3, MSB first -> one cycle after the 16th bit, val pulse, data_o = 0xA5C3, mod_o = 0; busy_o high for 15 cycles.
2. Partial word: valid bits 1,0,1,1,0, then valid low -> val pulse, data_o = 0xB000, mod_o = 5.
3. Short fragment: 2 bits then valid low -> no val pulse; outputs keep their prior value; with DESERIALIZER_FRAG_ERR_EN, frag_err_o pulses once.
4. Continuous stream: 32 contiguous bits of 0x1234 followed by 0xFEDC -> two val pulses exactly 16 cycles apart, carrying the correct words, both with mod 0.
5. Reset mid-word: arst_n_i asserted after 7 bits -> outputs go to 0 immediately with no pulse; a following 16-bit 0x8001 word is received correctly.
6. Loopback with the serializer: 1000 random data values with data_mod in {0, 3..15} -> every word matches, with received mod equal to the sent mod and bits below the mod zeroed.

Source files
------------

// File: rtl/ser_pkg.sv
// Definitions shared by the serializer/deserializer loopback pair: state encoding,
// minimum transaction length and the bit-count to data_mod conversion.
package ser_pkg;

  typedef enum logic {
    IDLE_S = 1'b0,
    RECV_S = 1'b1
  } state_t;

  localparam int unsigned MIN_TRANSACTION_LEN = 3;

  // A full-width word is encoded as 0; any shorter count is carried as-is.
  function automatic int unsigned to_data_mod(input int unsigned bit_count,
                                              input int unsigned bus_width);
    return (bit_count >= bus_width) ? 0 : bit_count;
  endfunction

endpackage

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver producing words plus a data_mod bit count.
// Optional DESERIALIZER_FRAG_ERR_EN adds frag_err_o, pulsing when a 1-2 bit fragment is dropped.
module deserializer
  import ser_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o
`ifdef DESERIALIZER_FRAG_ERR_EN
  ,
  output logic                      frag_err_o
`endif
);

  localparam logic [DATA_MOD_WIDTH-1:0] LAST_CNT = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);
  localparam logic [DATA_MOD_WIDTH-1:0] MIN_CNT  = DATA_MOD_WIDTH'(MIN_TRANSACTION_LEN);
  localparam logic [DATA_MOD_WIDTH-1:0] FULL_MOD =
    DATA_MOD_WIDTH'(to_data_mod(DATA_BUS_WIDTH, DATA_BUS_WIDTH));

  state_t                    r_state;
  logic [DATA_MOD_WIDTH-1:0] r_bit_cnt;
  logic [DATA_BUS_WIDTH-1:0] r_buf;
  logic [DATA_BUS_WIDTH-1:0] r_data;
  logic [DATA_MOD_WIDTH-1:0] r_mod;
  logic                      r_val;

  state_t                    w_state_next;
  logic [DATA_MOD_WIDTH-1:0] w_cnt_next;
  logic [DATA_BUS_WIDTH-1:0] w_buf_next;
  logic [DATA_MOD_WIDTH-1:0] w_idx;
  logic                      w_emit;
  logic [DATA_BUS_WIDTH-1:0] w_emit_data;
  logic [DATA_MOD_WIDTH-1:0] w_emit_mod;
`ifdef DESERIALIZER_FRAG_ERR_EN
  logic                      r_frag_err;
  logic                      w_frag;
`endif

  // Bit k of a word lands at index DATA_BUS_WIDTH-1-k.
  assign w_idx = LAST_CNT - r_bit_cnt;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_bit_cnt;
    w_buf_next   = r_buf;
    w_emit       = 1'b0;
    w_emit_data  = r_buf;
    w_emit_mod   = '0;
`ifdef DESERIALIZER_FRAG_ERR_EN
    w_frag       = 1'b0;
`endif
    case (r_state)
      IDLE_S: begin
        if (ser_data_val_i) begin
          w_buf_next                   = '0;
          w_buf_next[DATA_BUS_WIDTH-1] = ser_data_i;
          w_cnt_next                   = DATA_MOD_WIDTH'(1);
          w_state_next                 = RECV_S;
        end
      end
      RECV_S: begin
        if (ser_data_val_i) begin
          if (r_bit_cnt == LAST_CNT) begin
            w_emit_data[w_idx] = ser_data_i;
            w_emit             = 1'b1;
            w_emit_mod         = FULL_MOD;
            w_buf_next         = '0;
            w_cnt_next         = '0;
            w_state_next       = IDLE_S;
          end else begin
            w_buf_next[w_idx] = ser_data_i;
            w_cnt_next        = r_bit_cnt + DATA_MOD_WIDTH'(1);
          end
        end else begin
          // Burst ended early: emit if long enough, otherwise drop the fragment.
          if (r_bit_cnt >= MIN_CNT) begin
            w_emit     = 1'b1;
            w_emit_mod = DATA_MOD_WIDTH'(to_data_mod(32'(r_bit_cnt), DATA_BUS_WIDTH));
          end else begin
`ifdef DESERIALIZER_FRAG_ERR_EN
            w_frag = 1'b1;
`endif
          end
          w_buf_next   = '0;
          w_cnt_next   = '0;
          w_state_next = IDLE_S;
        end
      end
      default: begin
        w_buf_next   = '0;
        w_cnt_next   = '0;
        w_state_next = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= IDLE_S;
      r_bit_cnt <= '0;
      r_buf     <= '0;
      r_data    <= '0;
      r_mod     <= '0;
      r_val     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_cnt_next;
      r_buf     <= w_buf_next;
      r_val     <= w_emit;
      if (w_emit) begin
        r_data <= w_emit_data;
        r_mod  <= w_emit_mod;
      end
    end
  end

`ifdef DESERIALIZER_FRAG_ERR_EN
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_frag_err <= 1'b0;
    else           r_frag_err <= w_frag;
  end

  assign frag_err_o = r_frag_err;
`endif

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;
  assign busy_o           = (r_state == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Directed plus randomized loopback test of deserializer, using a scoreboard of expected words.
module tb_deserializer;

  localparam int W  = 16;
  localparam int MW = 4;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [MW-1:0] mod;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          arst_n_i = 1'b0;
  logic          ser_data_i = 1'b0;
  logic          ser_data_val_i = 1'b0;
  logic [W-1:0]  deser_data_o;
  logic [MW-1:0] deser_data_mod_o;
  logic          deser_data_val_o;
  logic          busy_o;
`ifdef DESERIALIZER_FRAG_ERR_EN
  logic          frag_err_o;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_pulses = 0;
  int   n_frag = 0;
  int   busy_cnt = 0;
  exp_t exp_q[$];
  int   pulse_cyc[$];

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
`ifdef DESERIALIZER_FRAG_ERR_EN
    ,
    .frag_err_o       (frag_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest expected word.
  always @(negedge clk_i) begin
    if (busy_o === 1'b1) busy_cnt++;
`ifdef DESERIALIZER_FRAG_ERR_EN
    if (frag_err_o === 1'b1) n_frag++;
`endif
    if (deser_data_val_o === 1'b1) begin
      n_pulses++;
      pulse_cyc.push_back(cyc);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: observed data=%h mod=%0d, required no pulse",
               deser_data_o, deser_data_mod_o);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert ({deser_data_o, deser_data_mod_o} === {e.data, e.mod}) else begin
          errors++;
          $error("FAIL word: observed data=%h mod=%0d, required data=%h mod=%0d",
                 deser_data_o, deser_data_mod_o, e.data, e.mod);
        end
        $display("word %0d: data=%h mod=%0d at cycle %0d", n_pulses, deser_data_o,
                 deser_data_mod_o, cyc);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_i);
    ser_data_val_i = 1'b1;
    ser_data_i     = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      ser_data_val_i = 1'b0;
      ser_data_i     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_word(input logic [W-1:0] d, input int nbits);
    for (int k = 0; k < nbits; k++) send_bit(d[W-1-k]);
  endtask

  task automatic expect_word(input logic [W-1:0] d, input int nbits);
    exp_t         e;
    logic [W-1:0] ones;
    ones   = '1;
    e.data = d & (ones << (W - nbits));
    e.mod  = (nbits == W) ? MW'(0) : MW'(nbits);
    exp_q.push_back(e);
  endtask

  initial begin
    int          p0;
    logic [W-1:0] d;
    int          m;
    int          nb;

    // Reset state
    repeat (3) @(negedge clk_i);
    checks++;
    assert ({deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o} === '0) else begin
      errors++;
      $error("FAIL reset_state: observed data=%h mod=%0d val=%b busy=%b, required all 0",
             deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o);
    end
    arst_n_i = 1'b1;
    idle(2);

    // 1: full word with latency and busy duration
    busy_cnt = 0;
    expect_word(16'hA5C3, 16);
    send_word(16'hA5C3, 16);
    @(negedge clk_i);
    ser_data_val_i = 1'b0;
    checks++;
    assert (deser_data_val_o === 1'b1) else begin
      errors++;
      $error("FAIL full_latency: observed val=%b, required 1", deser_data_val_o);
    end
    idle(2);
    checks++;
    assert (busy_cnt == 15) else begin
      errors++;
      $error("FAIL busy_cycles: observed %0d, required 15", busy_cnt);
    end

    // 2: partial 5-bit word -> 0xB000 mod 5
    expect_word(16'hB000, 5);
    send_word(16'hB000, 5);
    idle(3);

    // 3: 2-bit fragment is dropped, outputs hold
    p0 = n_pulses;
    send_word(16'hC000, 2);
    idle(3);
    checks++;
    assert (n_pulses == p0) else begin
      errors++;
      $error("FAIL frag_no_pulse: observed %0d pulses, required %0d", n_pulses, p0);
    end
    checks++;
    assert ({deser_data_o, deser_data_mod_o} === {16'hB000, 4'd5}) else begin
      errors++;
      $error("FAIL frag_hold: observed data=%h mod=%0d, required data=b000 mod=5",
             deser_data_o, deser_data_mod_o);
    end
`ifdef DESERIALIZER_FRAG_ERR_EN
    checks++;
    assert (n_frag == 1) else begin
      errors++;
      $error("FAIL frag_err: observed %0d pulses, required 1", n_frag);
    end
`endif

    // 4: continuous 32-bit stream -> two words 16 cycles apart
    p0 = pulse_cyc.size();
    expect_word(16'h1234, 16);
    expect_word(16'hFEDC, 16);
    send_word(16'h1234, 16);
    send_word(16'hFEDC, 16);
    idle(3);
    checks++;
    assert (pulse_cyc.size() == p0 + 2) else begin
      errors++;
      $error("FAIL stream_pulses: observed %0d, required %0d", pulse_cyc.size(), p0 + 2);
    end
    if (pulse_cyc.size() == p0 + 2) begin
      checks++;
      assert (pulse_cyc[p0+1] - pulse_cyc[p0] == 16) else begin
        errors++;
        $error("FAIL stream_spacing: observed %0d, required 16",
               pulse_cyc[p0+1] - pulse_cyc[p0]);
      end
    end

    // 5: asynchronous reset after 7 bits
    p0 = n_pulses;
    send_word(16'h7F00, 7);
    @(negedge clk_i);
    #2 arst_n_i = 1'b0;
    #1;
    checks++;
    assert ({deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o} === '0) else begin
      errors++;
      $error("FAIL async_reset: observed data=%h mod=%0d val=%b busy=%b, required all 0",
             deser_data_o, deser_data_mod_o, deser_data_val_o, busy_o);
    end
    ser_data_val_i = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    idle(2);
    checks++;
    assert (n_pulses == p0) else begin
      errors++;
      $error("FAIL reset_no_pulse: observed %0d pulses, required %0d", n_pulses, p0);
    end
    expect_word(16'h8001, 16);
    send_word(16'h8001, 16);
    idle(3);

    // 6: randomized loopback, mod in {0, 3..15}, optional back-to-back full words
    for (int t = 0; t < 1000; t++) begin
      d  = W'($urandom);
      m  = $urandom_range(2, 15);
      if (m == 2) m = 0;
      nb = (m == 0) ? W : m;
      expect_word(d, nb);
      send_word(d, nb);
      if (m != 0 || $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(4);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_words: observed %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
